// File: rtl/int_sched.sv
// Fixed-priority interrupt scheduler for the PicoBlaze I/O subsystem.
// Latches source edges, arbitrates lowest index first and sequences the CPU handshake.
module int_sched #(
  parameter int         NSRC      = 4,
  parameter logic [7:0] ADDR_MASK = 8'h10,
  parameter logic [7:0] ADDR_PEND = 8'h11,
  parameter logic [7:0] ADDR_STAT = 8'h12,
  parameter logic [7:0] ADDR_EOI  = 8'h13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      address,
  input  logic [7:0]      value_in,
  input  logic            wen,
  input  logic            ren,
  output logic [7:0]      port_out,
  input  logic [NSRC-1:0] irq_src,
  output logic [NSRC-1:0] src_ack,
  output logic            interrupt,
  input  logic            interrupt_ack
);
  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE} state_t;

  state_t          state_q;
  logic [NSRC-1:0] mask_q, pend_q, irqd_q, ack_q;
  logic [NSRC-1:0] pend_d, elig, grant_oh, wr_clr;
  logic [2:0]      cur_id_q, next_id;
  logic            int_q, grant;
  logic [7:0]      port_q, stat, vin_unused;

  assign vin_unused = value_in;
  assign elig       = pend_q & mask_q;
  assign grant      = (state_q == ASSERT) && interrupt_ack;
  assign wr_clr     = (wen && address == ADDR_PEND) ? value_in[NSRC-1:0] : '0;
  // Set is OR'ed in last so a new edge survives a same-cycle clear.
  assign pend_d     = (pend_q & ~(wr_clr | grant_oh)) | (irq_src & ~irqd_q);
  assign stat       = {state_q != IDLE, int_q, 3'b000, cur_id_q};

  always_comb begin
    next_id = '0;
    for (int i = NSRC-1; i >= 0; i--)
      if (elig[i]) next_id = 3'(i);
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NSRC; i++)
      grant_oh[i] = grant && (cur_id_q == 3'(i));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      pend_q   <= '0;
      irqd_q   <= '0;
      ack_q    <= '0;
      cur_id_q <= '0;
      int_q    <= 1'b0;
      port_q   <= '0;
    end else begin
      irqd_q <= irq_src;
      pend_q <= pend_d;
      ack_q  <= '0;
      if (wen && address == ADDR_MASK) mask_q <= value_in[NSRC-1:0];
      if (ren) begin
        if (address == ADDR_MASK)      port_q <= 8'(mask_q);
        else if (address == ADDR_PEND) port_q <= 8'(pend_q);
        else if (address == ADDR_STAT) port_q <= stat;
      end
      case (state_q)
        IDLE: if (|elig) begin
          cur_id_q <= next_id;
          int_q    <= 1'b1;
          state_q  <= ASSERT;
        end
        ASSERT: if (interrupt_ack) begin
          int_q   <= 1'b0;
          ack_q   <= grant_oh;
          state_q <= SERVICE;
        end
        SERVICE: if (wen && address == ADDR_EOI) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign port_out  = port_q;
  assign src_ack   = ack_q;
  assign interrupt = int_q;
endmodule

// File: tb/tb_int_sched.sv
// Cycle-vector bench for int_sched: per-cycle expected outputs from a table,
// read data checked through a scoreboard queue, plus a bounded latency sequence.
module tb_int_sched;
  localparam logic [7:0] M = 8'h10, P = 8'h11, S = 8'h12, E = 8'h13;

  logic       clk = 1'b0, rst = 1'b0, wen = 1'b0, ren = 1'b0, interrupt_ack = 1'b0;
  logic [7:0] address = '0, value_in = '0, port_out;
  logic [3:0] irq_src = '0, src_ack;
  logic       interrupt;

  int_sched #(.NSRC(4)) dut (
    .clk(clk), .rst(rst), .address(address), .value_in(value_in),
    .wen(wen), .ren(ren), .port_out(port_out), .irq_src(irq_src),
    .src_ack(src_ack), .interrupt(interrupt), .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, wen, ren;
    logic [7:0] addr, din;
    logic [3:0] irq;
    logic       iack;
    logic       exp_int;
    logic [3:0] exp_ack;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] rd_q[$];
  int         n_chk = 0, n_fail = 0;

  task automatic add(input logic r, input logic w, input logic rd, input logic [7:0] a,
                     input logic [7:0] d, input logic [3:0] irq, input logic ia,
                     input logic ei, input logic [3:0] ea, input logic [7:0] er);
    vec_t v;
    v.rst = r; v.wen = w; v.ren = rd; v.addr = a; v.din = d; v.irq = irq; v.iack = ia;
    v.exp_int = ei; v.exp_ack = ea; v.exp_rd = er;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; wen = v.wen; ren = v.ren; address = v.addr; value_in = v.din;
    irq_src = v.irq; interrupt_ack = v.iack;
    if (v.ren) rd_q.push_back(v.exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    // rst wen ren addr din irq iack | int ack rd
    add(1,0,0,0,0,4'h0,0, 0,4'h0,8'h00);
    add(0,0,1,S,0,4'h0,0, 0,4'h0,8'h00);
    add(0,0,1,P,0,4'h0,0, 0,4'h0,8'h00);
    add(0,0,1,M,0,4'h0,0, 0,4'h0,8'h00);
    // single source 2, held level
    add(0,1,0,M,8'h0F,4'h0,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h4,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h4,0, 1,4'h0,0);
    add(0,0,1,S,0,4'h4,0, 1,4'h0,8'hC2);
    add(0,0,0,0,0,4'h4,1, 0,4'h4,0);
    add(0,0,1,S,0,4'h4,0, 0,4'h0,8'h82);
    add(0,1,0,E,0,4'h4,0, 0,4'h0,0);
    add(0,0,1,S,0,4'h4,0, 0,4'h0,8'h02);
    add(0,0,1,P,0,4'h4,0, 0,4'h0,8'h00);
    add(0,0,0,0,0,4'h0,0, 0,4'h0,0);
    // sources 3 and 1 together
    add(0,0,0,0,0,4'hA,0, 0,4'h0,0);
    add(0,0,0,0,0,4'hA,0, 1,4'h0,0);
    add(0,0,1,S,0,4'hA,0, 1,4'h0,8'hC1);
    add(0,0,0,0,0,4'hA,1, 0,4'h2,0);
    add(0,1,0,E,0,4'h8,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h8,0, 1,4'h0,0);
    add(0,0,1,P,0,4'h8,0, 1,4'h0,8'h08);
    add(0,0,0,0,0,4'h8,1, 0,4'h8,0);
    add(0,0,1,P,0,4'h0,0, 0,4'h0,8'h00);
    add(0,1,0,E,0,4'h0,0, 0,4'h0,0);
    // masked pending, then unmask
    add(0,1,0,M,8'h00,4'h0,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h1,0, 0,4'h0,0);
    add(0,0,1,P,0,4'h1,0, 0,4'h0,8'h01);
    add(0,1,0,M,8'h01,4'h1,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h1,0, 1,4'h0,0);
    add(0,0,0,0,0,4'h1,1, 0,4'h1,0);
    add(0,1,0,E,0,4'h0,0, 0,4'h0,0);
    // cleared by W1C before unmask
    add(0,1,0,M,8'h00,4'h0,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h1,0, 0,4'h0,0);
    add(0,1,0,P,8'h01,4'h0,0, 0,4'h0,0);
    add(0,0,1,P,0,4'h0,0, 0,4'h0,8'h00);
    add(0,1,0,M,8'h01,4'h0,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h0,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h0,0, 0,4'h0,0);
    // new edge during SERVICE waits for EOI
    add(0,0,0,0,0,4'h1,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h1,0, 1,4'h0,0);
    add(0,0,0,0,0,4'h1,1, 0,4'h1,0);
    add(0,0,0,0,0,4'h0,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h1,0, 0,4'h0,0);
    add(0,0,1,P,0,4'h1,0, 0,4'h0,8'h01);
    add(0,0,0,0,0,4'h1,0, 0,4'h0,0);
    add(0,1,0,E,0,4'h1,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h1,0, 1,4'h0,0);
    // set coincides with grant clear: set survives
    add(0,0,0,0,0,4'h0,0, 1,4'h0,0);
    add(0,0,0,0,0,4'h1,1, 0,4'h1,0);
    add(0,0,1,P,0,4'h1,0, 0,4'h0,8'h01);
    add(0,1,0,E,0,4'h1,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h1,0, 1,4'h0,0);
    add(0,0,0,0,0,4'h1,1, 0,4'h1,0);
    add(0,1,0,E,0,4'h1,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h1,0, 0,4'h0,0);
    // reset while in ASSERT
    add(0,1,0,M,8'h0F,4'h0,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h2,0, 0,4'h0,0);
    add(0,0,0,0,0,4'h2,0, 1,4'h0,0);
    add(1,0,0,0,0,4'h0,0, 0,4'h0,0);
    add(0,0,1,S,0,4'h0,0, 0,4'h0,8'h00);
    add(0,0,1,P,0,4'h0,0, 0,4'h0,8'h00);
    add(0,0,1,M,0,4'h0,0, 0,4'h0,8'h00);
    add(0,1,0,E,0,4'h0,0, 0,4'h0,0);
    add(0,0,1,S,0,4'h0,0, 0,4'h0,8'h00);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      chk($sformatf("v%0d interrupt", i), {7'b0, interrupt}, {7'b0, vecs[i].exp_int});
      chk($sformatf("v%0d src_ack", i), {4'b0, src_ack}, {4'b0, vecs[i].exp_ack});
      if (vecs[i].ren) chk($sformatf("v%0d port_out", i), port_out, rd_q.pop_front());
    end

    // Hand sequence: interrupt latency and ack handshake with bounded waits.
    begin
      vec_t v;
      int lat;
      v = '{default: '0};
      v.wen = 1; v.addr = M; v.din = 8'h0F; drive(v);
      v = '{default: '0};
      v.irq = 4'h8; drive(v);
      lat = 1;
      while (!interrupt && lat < 10) begin drive(v); lat++; end
      chk("irq latency edges", 8'(lat), 8'd2);
      v.iack = 1; drive(v);
      chk("ack id3", {4'b0, src_ack}, 8'h08);
      v.iack = 0; v.ren = 1; v.addr = S; v.exp_rd = 8'h83; drive(v);
      chk("stat service id3", port_out, rd_q.pop_front());
      chk("ack single cycle", {4'b0, src_ack}, 8'h00);
      v.ren = 0; v.wen = 1; v.addr = E; drive(v);
      v.wen = 0;
      for (int k = 0; k < 5; k++) begin
        drive(v);
        chk($sformatf("held level no reirq %0d", k), {7'b0, interrupt}, 8'h00);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/int_sched.md
Name: int_sched

Overview:
- Interrupt scheduler for the PicoBlaze I/O subsystem.
- Collects up to 8 interrupt requests from IOC input ports and timer/peripheral blocks, and arbitrates them by fixed priority (lowest index wins).
- Drives the single CPU interrupt line and returns a one-cycle acknowledge to the granted source.
- Mask, pending, status and end-of-interrupt (EOI) registers sit on the CPU port bus. The read register feeds the input-port selector mux.

Parameters:
- NSRC, 4, number of request sources, 1..8.
- ADDR_MASK, 8'h10, port address of the mask register (R/W).
- ADDR_PEND, 8'h11, port address of the pending register (R, write-1-to-clear).
- ADDR_STAT, 8'h12, port address of the status register (R).
- ADDR_EOI, 8'h13, port address of the EOI strobe (W, data ignored).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active high
- address  in  8  CPU port_id
- value_in  in  8  CPU out_port data
- wen  in  1  CPU write strobe
- ren  in  1  CPU read strobe
- port_out  out  8  registered read data, to the input-port selector
- irq_src  in  NSRC  request levels; high from event until acknowledged
- src_ack  out  NSRC  one-cycle acknowledge pulse per source
- interrupt  out  1  interrupt line to the CPU
- interrupt_ack  in  1  CPU interrupt acknowledge pulse

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - mask=0, pending=0, irq_d=0, cur_id=0, state=IDLE.
  - interrupt=0, src_ack=0, port_out=0.
  - Reset mid-operation aborts any in-flight interrupt with no src_ack pulse.
- Edge capture:
  - irq_d <= irq_src each cycle.
  - Bit i of pending sets on a rising edge: irq_src[i] & ~irq_d[i].
  - A level held high produces exactly one pending event.
  - Pending bits latch regardless of mask.
- Pending clear:
  - Cleared by the grant (see ASSERT) or by CPU write to ADDR_PEND with bit=1.
  - If a set and a clear hit the same bit in the same cycle, the set wins.
- Mask write:
  - wen & address==ADDR_MASK: mask <= value_in[NSRC-1:0].
  - Unused bits read 0.
- Reads:
  - On ren at ADDR_MASK, ADDR_PEND or ADDR_STAT, port_out <= register value one cycle later.
  - Otherwise port_out holds its value.
  - Status format: bit7 = busy (state!=IDLE), bit6 = interrupt, bits5:3 = 0, bits2:0 = cur_id.
- FSM, three states:
  - IDLE:
    - If (pending & mask) != 0: cur_id <= lowest set index, interrupt <= 1, go to ASSERT.
    - interrupt rises 1 cycle after the eligible pending bit is registered, i.e. 2 clk edges after the source edge.
  - ASSERT:
    - Hold interrupt=1 until interrupt_ack=1.
    - On that edge: interrupt <= 0, src_ack[cur_id] <= 1 for exactly one cycle, pending[cur_id] <= 0 (set-wins rule applies), go to SERVICE.
    - Mask changes during ASSERT do not withdraw the interrupt.
  - SERVICE:
    - Busy; no new arbitration.
    - wen & address==ADDR_EOI: go to IDLE, and arbitration is possible on the next cycle.
    - An EOI write in IDLE or ASSERT is ignored.
- Multiple pending sources are served one per IDLE→ASSERT→SERVICE→IDLE pass, lowest index first.
- Sources at index >= NSRC do not exist. src_ack only ever pulses one bit at a time.

Test Plan:
- Reset, then read ADDR_STAT, ADDR_PEND and ADDR_MASK -> port_out = 8'h00 each; interrupt=0.
- mask=8'h0F; irq_src[2] rises and is held -> interrupt=1 two edges later; STAT reads 8'hC2. Pulse interrupt_ack -> src_ack=4'b0100 for 1 cycle; interrupt=0; STAT reads 8'h82. Write EOI -> STAT reads 8'h02; irq_src[2] still high causes no second interrupt.
- mask=8'h0F; irq_src[3] and irq_src[1] rise in the same cycle -> id 1 is served first. After ack+EOI, a second interrupt fires with cur_id=3; PEND reads 8'h08 before the second ack and 8'h00 after it.
- mask=8'h00; irq_src[0] rises -> PEND=8'h01 and no interrupt. Write mask=8'h01 -> interrupt rises on the next cycle. Alternative path: write PEND=8'h01 first -> PEND=8'h00 and no interrupt after unmasking.
- In SERVICE for id 0, a new rising edge on irq_src[0] -> pending[0] set, no interrupt until EOI, then interrupt fires one cycle after the EOI edge. Set and ack on the same bit in the same cycle -> pending bit remains 1.
- While in ASSERT, assert rst for one cycle -> interrupt=0, no src_ack pulse, state=IDLE, all registers 0. An EOI written in IDLE has no effect.
